// File: rtl/rs_issue_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : rs_issue_scheduler
//  Description : Unified reservation station. Holds dispatched uops, tracks
//                operand readiness through wakeup broadcasts, and for each
//                issue port selects the oldest ready uop using an age matrix.
//  Revision    : 1.0 - initial release
// ============================================================================
module rs_issue_scheduler #(
    parameter int RS_ENTRIES   = 8,
    parameter int NUM_PREGS    = 128,
    parameter int NUM_ROB_ENTS = 64,
    parameter int DISP_WIDTH   = 2,
    parameter int NUM_FUS      = 4,
    localparam int PW = $clog2(NUM_PREGS),
    localparam int RW = $clog2(NUM_ROB_ENTS),
    localparam int EW = $clog2(RS_ENTRIES),
    localparam int CW = $clog2(RS_ENTRIES) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DISP_WIDTH-1:0]   disp_valid,
    input  logic [DISP_WIDTH*2-1:0] disp_pipe,
    input  logic [DISP_WIDTH*PW-1:0] disp_src1_preg,
    input  logic [DISP_WIDTH*PW-1:0] disp_src2_preg,
    input  logic [DISP_WIDTH-1:0]   disp_src1_rdy,
    input  logic [DISP_WIDTH-1:0]   disp_src2_rdy,
    input  logic [DISP_WIDTH*PW-1:0] disp_dst_preg,
    input  logic [DISP_WIDTH*RW-1:0] disp_rob_index,
    output logic                    disp_ready,
    input  logic [NUM_FUS-1:0]      wake_valid,
    input  logic [NUM_FUS*PW-1:0]   wake_preg,
    input  logic [NUM_FUS-1:0]      fu_ready,
    output logic [NUM_FUS-1:0]      iss_valid,
    output logic [NUM_FUS*EW-1:0]   iss_entry,
    output logic [NUM_FUS*PW-1:0]   iss_src1_preg,
    output logic [NUM_FUS*PW-1:0]   iss_src2_preg,
    output logic [NUM_FUS*PW-1:0]   iss_dst_preg,
    output logic [NUM_FUS*RW-1:0]   iss_rob_index,
    input  logic                    flush,
    output logic [CW-1:0]           free_count
);

    // Slot storage
    logic [RS_ENTRIES-1:0] r_valid;
    logic [RS_ENTRIES-1:0] r_s1_rdy;
    logic [RS_ENTRIES-1:0] r_s2_rdy;
    logic [1:0]            r_pipe [RS_ENTRIES];
    logic [PW-1:0]         r_s1   [RS_ENTRIES];
    logic [PW-1:0]         r_s2   [RS_ENTRIES];
    logic [PW-1:0]         r_dst  [RS_ENTRIES];
    logic [RW-1:0]         r_rob  [RS_ENTRIES];
    // r_age[i][j] = 1 means slot i is older than slot j
    logic [RS_ENTRIES-1:0] r_age  [RS_ENTRIES];

    logic [CW-1:0]             w_free_cnt;
    logic [DISP_WIDTH-1:0]     w_lane_en;
    logic [EW-1:0]             w_lane_slot [DISP_WIDTH];
    logic [RS_ENTRIES-1:0]     w_taken;
    logic                      w_found;
    logic [NUM_FUS*RS_ENTRIES-1:0] w_clr_flat;
    logic [RS_ENTRIES-1:0]     w_issue_clr;

    // True when any valid broadcast this cycle carries the given preg
    function automatic logic f_wake_hit(
        input logic [PW-1:0]         preg,
        input logic [NUM_FUS-1:0]    wv,
        input logic [NUM_FUS*PW-1:0] wp
    );
        logic hit;
        hit = 1'b0;
        for (int f = 0; f < NUM_FUS; f++) begin
            if (wv[f] && (wp[f*PW +: PW] == preg)) hit = 1'b1;
        end
        return hit;
    endfunction

    // Count empty slots from registered state only (issuing slots still count as used)
    always_comb begin
        w_free_cnt = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            if (!r_valid[i]) w_free_cnt = w_free_cnt + CW'(1);
        end
    end

    assign free_count = w_free_cnt;
    assign disp_ready = (w_free_cnt >= CW'(DISP_WIDTH));

    // Allocate the lowest free slots to accepted lanes, lower lane first
    always_comb begin
        w_taken   = '0;
        w_found   = 1'b0;
        w_lane_en = '0;
        for (int k = 0; k < DISP_WIDTH; k++) begin
            w_lane_slot[k] = '0;
            w_found        = 1'b0;
            if (disp_valid[k] && disp_ready && !flush) begin
                for (int i = 0; i < RS_ENTRIES; i++) begin
                    if (!w_found && !r_valid[i] && !w_taken[i]) begin
                        w_found        = 1'b1;
                        w_taken[i]     = 1'b1;
                        w_lane_slot[k] = EW'(i);
                        w_lane_en[k]   = 1'b1;
                    end
                end
            end
        end
    end

    generate
        for (genvar p = 0; p < NUM_FUS; p++) begin : g_port
            logic [RS_ENTRIES-1:0] w_cand;
            logic [RS_ENTRIES-1:0] w_sel;
            logic [EW-1:0]         w_idx;

            // Ready candidates for this port and the single oldest among them
            always_comb begin
                w_cand = '0;
                for (int i = 0; i < RS_ENTRIES; i++) begin
                    w_cand[i] = r_valid[i] && (r_pipe[i] == 2'(p)) && r_s1_rdy[i] && r_s2_rdy[i];
                end
                w_sel = '0;
                for (int i = 0; i < RS_ENTRIES; i++) begin
                    w_sel[i] = w_cand[i];
                    for (int j = 0; j < RS_ENTRIES; j++) begin
                        if ((j != i) && w_cand[j] && !r_age[i][j]) w_sel[i] = 1'b0;
                    end
                end
                w_idx = '0;
                for (int i = 0; i < RS_ENTRIES; i++) begin
                    if (w_sel[i]) w_idx = EW'(i);
                end
            end

            assign iss_valid[p]                = (|w_cand) && fu_ready[p] && !flush;
            assign iss_entry[p*EW +: EW]       = w_idx;
            assign iss_src1_preg[p*PW +: PW]   = r_s1[w_idx];
            assign iss_src2_preg[p*PW +: PW]   = r_s2[w_idx];
            assign iss_dst_preg[p*PW +: PW]    = r_dst[w_idx];
            assign iss_rob_index[p*RW +: RW]   = r_rob[w_idx];
            assign w_clr_flat[p*RS_ENTRIES +: RS_ENTRIES] = iss_valid[p] ? w_sel : '0;
        end
    endgenerate

    // Merge per-port issue selections into one slot-invalidate mask
    always_comb begin
        w_issue_clr = '0;
        for (int p = 0; p < NUM_FUS; p++) begin
            w_issue_clr = w_issue_clr | w_clr_flat[p*RS_ENTRIES +: RS_ENTRIES];
        end
    end

    // Slot state update: reset/flush clear, issue invalidate, wakeup, dispatch write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= '0;
            r_s1_rdy <= '0;
            r_s2_rdy <= '0;
            for (int i = 0; i < RS_ENTRIES; i++) begin
                r_pipe[i] <= '0;
                r_s1[i]   <= '0;
                r_s2[i]   <= '0;
                r_dst[i]  <= '0;
                r_rob[i]  <= '0;
                r_age[i]  <= '0;
            end
        end else if (flush) begin
            r_valid <= '0;
            for (int i = 0; i < RS_ENTRIES; i++) begin
                r_age[i] <= '0;
            end
        end else begin
            for (int i = 0; i < RS_ENTRIES; i++) begin
                if (w_issue_clr[i]) r_valid[i] <= 1'b0;
                if (f_wake_hit(r_s1[i], wake_valid, wake_preg)) r_s1_rdy[i] <= 1'b1;
                if (f_wake_hit(r_s2[i], wake_valid, wake_preg)) r_s2_rdy[i] <= 1'b1;
            end
            // Later lanes override earlier ones so lane 0 ends up older than lane 1
            for (int k = 0; k < DISP_WIDTH; k++) begin
                if (w_lane_en[k]) begin
                    r_valid[w_lane_slot[k]]  <= 1'b1;
                    r_pipe[w_lane_slot[k]]   <= disp_pipe[k*2 +: 2];
                    r_s1[w_lane_slot[k]]     <= disp_src1_preg[k*PW +: PW];
                    r_s2[w_lane_slot[k]]     <= disp_src2_preg[k*PW +: PW];
                    r_dst[w_lane_slot[k]]    <= disp_dst_preg[k*PW +: PW];
                    r_rob[w_lane_slot[k]]    <= disp_rob_index[k*RW +: RW];
                    r_s1_rdy[w_lane_slot[k]] <= disp_src1_rdy[k] |
                        f_wake_hit(disp_src1_preg[k*PW +: PW], wake_valid, wake_preg);
                    r_s2_rdy[w_lane_slot[k]] <= disp_src2_rdy[k] |
                        f_wake_hit(disp_src2_preg[k*PW +: PW], wake_valid, wake_preg);
                    r_age[w_lane_slot[k]]    <= '0;
                    for (int j = 0; j < RS_ENTRIES; j++) begin
                        if (EW'(j) != w_lane_slot[k]) r_age[j][w_lane_slot[k]] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire
